// File: rtl/pc_ir_regfile.sv
// Fetch/decode datapath: PC, instruction register, RV32 ADD decode and a 32x32 register file.
// Define REGFILE_WRITEBACK_EN to compile in ADD writeback; otherwise the register file keeps its reset contents.
module pc_ir_regfile #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_data,
  output logic [31:0] pc_value,
  output logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  func3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  func7,
  output logic        is_add,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] alu_result
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] regs_q [32];
  logic        wr_en;
  logic [31:0] wr_data;

  always_comb begin
    pc_d    = pc_q + 32'(PC_STEP);
    instr_d = mem_data;
  end

  assign pc_value    = pc_q;
  assign instruction = instr_q;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign func3  = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign func7  = instr_q[31:25];

  assign is_add = (opcode == 7'b0110011) && (func3 == 3'b000) && (func7 == 7'b0000000);

  // Reads see pre-edge contents only; x0 is forced to zero at the read mux.
  assign rs1_data = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : regs_q[rs2];

  assign alu_result = is_add ? (rs1_data + rs2_data) : '0;

  always_comb begin
    wr_en   = is_add && (rd != 5'd0);
    wr_data = alu_result;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= i;
      end
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef REGFILE_WRITEBACK_EN
      if (wr_en) begin
        regs_q[rd] <= wr_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pc_ir_regfile.sv
// Scoreboard bench for pc_ir_regfile: directed vectors push expected post-edge state, a monitor pops and compares.
module tb_pc_ir_regfile;

`ifdef REGFILE_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  typedef struct {
    bit          rst_n;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [31:0] wpc;
    logic [31:0] ins;
    logic        add;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] alu;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_data = '0;

  logic [31:0] pc_value, instruction, rs1_data, rs2_data, alu_result;
  logic [6:0]  opcode, func7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  func3;
  logic        is_add;

  logic [31:0] w_pc, w_ins, w_r1, w_r2, w_alu;
  logic [6:0]  w_op, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_add;

  pc_ir_regfile dut (
    .clock(clock), .reset(reset), .mem_data(mem_data),
    .pc_value(pc_value), .instruction(instruction),
    .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2), .func7(func7),
    .is_add(is_add), .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_result(alu_result)
  );

  pc_ir_regfile #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_wrap (
    .clock(clock), .reset(reset), .mem_data(mem_data),
    .pc_value(w_pc), .instruction(w_ins),
    .opcode(w_op), .rd(w_rd), .func3(w_f3), .rs1(w_rs1), .rs2(w_rs2), .func7(w_f7),
    .is_add(w_add), .rs1_data(w_r1), .rs2_data(w_r2), .alu_result(w_alu)
  );

  always #5 clock = ~clock;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void addv(bit r, logic [31:0] m, logic [31:0] p, logic [31:0] wp,
                               logic [31:0] i, logic a, logic [31:0] d1, logic [31:0] d2,
                               logic [31:0] al);
    vec_t v;
    v.rst_n = r; v.mem = m; v.pc = p; v.wpc = wp; v.ins = i;
    v.add = a; v.r1 = d1; v.r2 = d2; v.alu = al;
    vecs.push_back(v);
  endfunction

  // Monitor: compares one expected record per cycle on the falling edge.
  int step_no = 0;
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      vec_t e;
      string s;
      e = sb.pop_front();
      s = $sformatf("v%0d", step_no);
      chk({s, ".pc"},       pc_value, e.pc);
      chk({s, ".wrap_pc"},  w_pc, e.wpc);
      chk({s, ".instr"},    instruction, e.ins);
      chk({s, ".fields"},   {func7, rs2, rs1, func3, rd, opcode}, e.ins);
      chk({s, ".is_add"},   {31'd0, is_add}, {31'd0, e.add});
      chk({s, ".rs1_data"}, rs1_data, e.r1);
      chk({s, ".rs2_data"}, rs2_data, e.r2);
      chk({s, ".alu"},      alu_result, e.alu);
      step_no++;
    end
  end

  initial begin
    // Reset then free-run: pc 0,4,8,12; wrap instance FFFFFFF8, FFFFFFFC, 0, 4.
    addv(0, 32'h0, 32'h0,  32'hFFFF_FFF8, 32'h0, 0, 0, 0, 0);
    addv(1, 32'h0, 32'h4,  32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0);
    addv(1, 32'h0, 32'h8,  32'h0000_0000, 32'h0, 0, 0, 0, 0);
    addv(1, 32'h0, 32'hC,  32'h0000_0004, 32'h0, 0, 0, 0, 0);
    addv(0, 32'h0, 32'h0,  32'hFFFF_FFF8, 32'h0, 0, 0, 0, 0);
    // add x3,x1,x2
    addv(1, 32'h002081B3, 32'h4,  32'hFFFF_FFFC, 32'h002081B3, 1, 1, 2, 3);
    // add x4,x3,x3 (x3 = 3 either way)
    addv(1, 32'h00318233, 32'h8,  32'h0000_0000, 32'h00318233, 1, 3, 3, 6);
    // add x5,x4,x0: x4 = 6 with writeback, else reset value 4
    addv(1, 32'h000202B3, 32'hC,  32'h0000_0004, 32'h000202B3, 1, WB ? 6 : 4, 0, WB ? 6 : 4);
    // sub x6,x5,x5: not an ADD
    addv(1, 32'h40528333, 32'h10, 32'h0000_0008, 32'h40528333, 0, WB ? 6 : 5, WB ? 6 : 5, 0);
    // add x0,x1,x2
    addv(1, 32'h00208033, 32'h14, 32'h0000_000C, 32'h00208033, 1, 1, 2, 3);
    // add x7,x6,x0: x6 untouched by sub, x0 still zero
    addv(1, 32'h000303B3, 32'h18, 32'h0000_0010, 32'h000303B3, 1, 6, 0, 6);
    // add x8,x0,x7: x7 = 6 with writeback, else 7
    addv(1, 32'h00700433, 32'h1C, 32'h0000_0014, 32'h00700433, 1, 0, WB ? 6 : 7, WB ? 6 : 7);
    // Reset while is_add=1: pending x8 write discarded
    addv(0, 32'h002081B3, 32'h0, 32'hFFFF_FFF8, 32'h0, 0, 0, 0, 0);
    // add x9,x8,x8: x8 back to reset value 8
    addv(1, 32'h008404B3, 32'h4, 32'hFFFF_FFFC, 32'h008404B3, 1, 8, 8, 16);

    foreach (vecs[k]) begin
      reset    = vecs[k].rst_n;
      mem_data = vecs[k].mem;
      @(posedge clock);
      #1;
      sb.push_back(vecs[k]);
    end

    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
